// File: rtl/adder_pkg.sv
// adder_pkg: definitions shared by the ripple-carry adder and its downstream
// stages. A result travels as a packed {cout, sum} word so every stage agrees
// on bit placement: bit RES_W-1 is the carry-out, bits ADD_W-1:0 the sum.
package adder_pkg;

  localparam int ADD_W = 8;
  localparam int RES_W = ADD_W + 1;

  typedef struct packed {
    logic             cout;
    logic [ADD_W-1:0] sum;
  } add_result_t;

  // Pack a carry-out and sum into the shared result layout.
  function automatic logic [RES_W-1:0] pack_result(input logic cout,
                                                   input logic [ADD_W-1:0] sum);
    add_result_t res_s;
    res_s.cout = cout;
    res_s.sum  = sum;
    return res_s;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears count
//   inc   - count up by one this cycle (ignored once saturated)
//   clr   - synchronous clear, wins over inc
//   count - current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Counter state: clear has priority, increment holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && !(&count_r)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/add_result_fifo.sv
// add_result_fifo: captures adder {cout, sum} results into a small
// first-word-fall-through FIFO and hands them to a consumer over valid/ready.
// Also tracks how many accepted results carried out (saturating) plus a
// sticky carry-out flag.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   in_valid/in_ready   - producer handshake; in_ready is low only when full
//   in_sum, in_cout     - adder result to store
//   out_valid/out_ready - consumer handshake for the head entry
//   out_data            - head entry {cout, sum}, zero while empty
//   level               - occupancy 0..DEPTH
//   ovf_count           - saturating count of accepted carry-out results
//   ovf_sticky          - set by any accepted carry-out result
//   clr_stats           - synchronous clear of ovf_count / ovf_sticky
module add_result_fifo
  import adder_pkg::*;
#(
  parameter int DATA_W = ADD_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_sum,
  input  logic                       in_cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W:0]            out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           ovf_count,
  output logic                       ovf_sticky,
  input  logic                       clr_stats
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_W:0]    mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LVL_W-1:0]   level_r;
  logic               sticky_r;
  logic               in_ready_s;
  logic               out_valid_s;
  logic               push_s;
  logic               pop_s;
  logic               ovf_inc_s;

  // Handshake qualifiers come from registered occupancy only, so a full FIFO
  // never accepts on the strength of a same-cycle pop.
  assign in_ready_s  = (level_r != FULL_LVL);
  assign out_valid_s = (level_r != {LVL_W{1'b0}});
  assign push_s      = in_valid & in_ready_s;
  assign pop_s       = out_valid_s & out_ready;
  assign ovf_inc_s   = push_s & in_cout;

  // Storage write; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      // {cout, sum} ordering matches the shared adder result layout
      mem_r[wr_ptr_r] <= {in_cout, in_sum};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky carry-out flag; clear wins over a simultaneous counting push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 1'b0;
    end else if (clr_stats) begin
      sticky_r <= 1'b0;
    end else if (ovf_inc_s) begin
      sticky_r <= 1'b1;
    end else begin
      sticky_r <= sticky_r;
    end
  end

  sat_counter #(.W(CNT_W)) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ovf_inc_s),
    .clr   (clr_stats),
    .count (ovf_count)
  );

  // Head entry presented only while valid; zeros hide stale storage.
  always_comb begin
    out_data = {(DATA_W + 1){1'b0}};
    if (out_valid_s) begin
      out_data = mem_r[rd_ptr_r];
    end else begin
      out_data = {(DATA_W + 1){1'b0}};
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign level      = level_r;
  assign ovf_sticky = sticky_r;

endmodule

// File: tb/tb_add_result_fifo.sv
module tb_add_result_fifo;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sum;
  logic       in_cout;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic [2:0] level;
  logic [7:0] ovf_count;
  logic       ovf_sticky;
  logic       clr_stats;

  add_result_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_cout    (in_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .ovf_count  (ovf_count),
    .ovf_sticky (ovf_sticky),
    .clr_stats  (clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a queue of stored results plus plain stats.
  logic [8:0] mq[$];
  int         m_cnt;
  bit         m_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model reaction to one rising edge, using the inputs held across it.
  task automatic model_step();
    bit push, pop;
    push = in_valid && (mq.size() < 4);
    pop  = out_ready && (mq.size() > 0);
    if (clr_stats) begin
      m_cnt    = 0;
      m_sticky = 1'b0;
    end else if (push && in_cout) begin
      m_cnt    = (m_cnt >= 255) ? 255 : m_cnt + 1;
      m_sticky = 1'b1;
    end
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back({in_cout, in_sum});
  endtask

  task automatic cycle(input logic v, input logic [7:0] s, input logic c,
                       input logic r, input logic cl);
    in_valid  = v;
    in_sum    = s;
    in_cout   = c;
    out_ready = r;
    clr_stats = cl;
    @(posedge clk);
    model_step();
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
  endtask

  // Compare process: every falling edge, DUT against the model.
  always @(negedge clk) begin
    chk("level",      32'(level),      32'(mq.size()));
    chk("in_ready",   32'(in_ready),   32'(mq.size() != 4));
    chk("out_valid",  32'(out_valid),  32'(mq.size() != 0));
    chk("out_data",   32'(out_data),   (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("ovf_count",  32'(ovf_count),  32'(m_cnt));
    chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
  end

  logic [8:0] fill_exp [4];

  initial begin
    fill_exp[0] = 9'h011; fill_exp[1] = 9'h122;
    fill_exp[2] = 9'h033; fill_exp[3] = 9'h144;
    m_cnt = 0; m_sticky = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_sum = 8'h00; in_cout = 1'b0;
    out_ready = 1'b0; clr_stats = 1'b0;
    #2;
    chk("rst_level",    32'(level),      32'd0);
    chk("rst_in_ready", 32'(in_ready),   32'd1);
    chk("rst_out_val",  32'(out_valid),  32'd0);
    chk("rst_out_data", 32'(out_data),   32'd0);
    chk("rst_ovf",      32'(ovf_count),  32'd0);
    chk("rst_sticky",   32'(ovf_sticky), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill, overfill, drain
    for (int i = 0; i < 4; i++) cycle(1'b1, fill_exp[i][7:0], fill_exp[i][8], 1'b0, 1'b0);
    chk("fill_level",    32'(level),    32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("overfill_level", 32'(level),     32'd4);
    chk("fill_ovf",       32'(ovf_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(out_data), 32'(fill_exp[i]));
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_level", 32'(level),     32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at level 2
    cycle(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
    chk("pp_head", 32'(out_data), 32'h00A);
    cycle(1'b1, 8'h0C, 1'b0, 1'b1, 1'b0);
    chk("pp_level", 32'(level),    32'd2);
    chk("pp_head2", 32'(out_data), 32'h00B);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("pp_head3", 32'(out_data), 32'h00C);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Wrap-around: push/pop pairs through a nearly empty FIFO
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
      chk("wrap_data", 32'(out_data), 32'(i));
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("wrap_empty", 32'(level), 32'd0);

    // Saturation, then clear against a counting push
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b1, 1'b0);
    chk("sat_count",  32'(ovf_count),  32'd255);
    chk("sat_sticky", 32'(ovf_sticky), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
    chk("clr_count",  32'(ovf_count),  32'd0);
    chk("clr_sticky", 32'(ovf_sticky), 32'd0);
    chk("clr_stored", 32'(out_data),   32'h15A);
    chk("clr_level",  32'(level),      32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 4));

    // Reset mid-operation at level 3
    for (int i = 0; i < 8 && mq.size() > 0; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd3);
    #2 rst_n = 1'b0;
    mq.delete(); m_cnt = 0; m_sticky = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    chk("mid_rst_level", 32'(level),     32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("post_rst_data",  32'(out_data), 32'h077);
    chk("post_rst_level", 32'(level),    32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
